ysyx_24090003_wbu: RTL and testbench



---
 rtl/ysyx_24090003_pkg.sv | 16 +
 rtl/ysyx_24090003_load_align.sv | 27 ++
 rtl/ysyx_24090003_wbu.sv | 131 +++++++++++++
 tb/tb_ysyx_24090003_wbu.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24090003_pkg.sv
// Shared types for the write-back unit: FSM states and load funct3 encodings.
package ysyx_24090003_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        WRITE    = 2'd2
    } wbu_state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;

endpackage

// File: rtl/ysyx_24090003_load_align.sv
// Combinational load alignment: picks the byte/half addressed by addr_lo
// and sign- or zero-extends it according to funct3.
module ysyx_24090003_load_align
    import ysyx_24090003_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] rdata,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{addr_lo, 3'b000} +: 8];
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            LB:      result = {{24{byte_sel[7]}}, byte_sel};
            LH:      result = {{16{half_sel[15]}}, half_sel};
            LBU:     result = {24'd0, byte_sel};
            LHU:     result = {16'd0, half_sel};
            default: result = rdata;  // LW and unused encodings pass the word through
        endcase
    end

endmodule

// File: rtl/ysyx_24090003_wbu.sv
// Write-back unit: accepts retiring instructions, waits for load data,
// drives the register-file write port and emits a commit pulse.
module ysyx_24090003_wbu
    import ysyx_24090003_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        exu_valid,
    output logic        exu_ready,
    input  logic [31:0] exu_pc,
    input  logic [4:0]  exu_rd,
    input  logic        exu_wen,
    input  logic        exu_is_load,
    input  logic [2:0]  exu_funct3,
    input  logic [1:0]  exu_addr_lo,
    input  logic [31:0] exu_result,
    input  logic        lsu_rvalid,
    input  logic [31:0] lsu_rdata,
    output logic        reg_write_enable,
    output logic [4:0]  EXrd,
    output logic [31:0] reg_write_data,
    output logic        wb_done,
    output logic [31:0] wb_pc,
    output logic        wb_err
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] TIMEOUT_C = CW'(MEM_TIMEOUT);

    wbu_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   pc_q, pc_d;
    logic [4:0]    rd_q, rd_d;
    logic          wen_q, wen_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    addr_lo_q, addr_lo_d;
    logic [31:0]   data_q, data_d;
    logic          err_q, err_d;

    logic [31:0]   load_data;
    logic [CW-1:0] cnt_inc;
    logic          xfer;

    ysyx_24090003_load_align u_align (
        .funct3  (funct3_q),
        .addr_lo (addr_lo_q),
        .rdata   (lsu_rdata),
        .result  (load_data)
    );

    assign exu_ready = (state_q != WAIT_MEM);
    assign xfer      = exu_valid && exu_ready;
    assign cnt_inc   = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pc_d      = pc_q;
        rd_d      = rd_q;
        wen_d     = wen_q;
        funct3_d  = funct3_q;
        addr_lo_d = addr_lo_q;
        data_d    = data_q;
        err_d     = err_q;
        case (state_q)
            WAIT_MEM: begin
                // Data arriving on the timeout cycle still completes the load.
                if (lsu_rvalid) begin
                    data_d  = load_data;
                    state_d = WRITE;
                end else if (cnt_inc == TIMEOUT_C) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                if (xfer) begin
                    pc_d      = exu_pc;
                    rd_d      = exu_rd;
                    wen_d     = exu_wen;
                    funct3_d  = exu_funct3;
                    addr_lo_d = exu_addr_lo;
                    if (exu_is_load) begin
                        cnt_d   = '0;
                        state_d = WAIT_MEM;
                    end else begin
                        data_d  = exu_result;
                        state_d = WRITE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pc_q      <= '0;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pc_q      <= pc_d;
            rd_q      <= rd_d;
            wen_q     <= wen_d;
            funct3_q  <= funct3_d;
            addr_lo_q <= addr_lo_d;
            data_q    <= data_d;
            err_q     <= err_d;
        end
    end

    assign wb_done          = (state_q == WRITE);
    assign reg_write_enable = wb_done && wen_q && (rd_q != 5'd0);
    assign EXrd             = rd_q;
    assign reg_write_data   = data_q;
    assign wb_pc            = pc_q;
    assign wb_err           = err_q;

endmodule

// File: tb/tb_ysyx_24090003_wbu.sv
// Randomized bench for the write-back unit against a transaction-level model.
module tb_ysyx_24090003_wbu;

    localparam int TMO = 8;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst;
    logic        exu_valid, exu_ready;
    logic [31:0] exu_pc, exu_result, lsu_rdata, reg_write_data, wb_pc;
    logic [4:0]  exu_rd, EXrd;
    logic        exu_wen, exu_is_load, lsu_rvalid;
    logic [2:0]  exu_funct3;
    logic [1:0]  exu_addr_lo;
    logic        reg_write_enable, wb_done, wb_err;

    int total = 0;
    int bad   = 0;
    logic exp_err = 1'b0;

    ysyx_24090003_wbu #(.MEM_TIMEOUT(TMO)) dut (
        .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
        .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_pc(exu_pc),
        .exu_rd(exu_rd), .exu_wen(exu_wen), .exu_is_load(exu_is_load),
        .exu_funct3(exu_funct3), .exu_addr_lo(exu_addr_lo), .exu_result(exu_result),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
        .reg_write_enable(reg_write_enable), .EXrd(EXrd), .reg_write_data(reg_write_data),
        .wb_done(wb_done), .wb_pc(wb_pc), .wb_err(wb_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge cpu_clk);
        #1;
    endtask

    // Load result straight from the ISA definition, using shifts and arithmetic.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a,
                                             input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * int'(a[1]))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                         input logic ld, input logic [2:0] f3, input logic [1:0] a,
                         input logic [31:0] res);
        exu_valid = 1'b1; exu_pc = pc; exu_rd = rd; exu_wen = wen; exu_is_load = ld;
        exu_funct3 = f3; exu_addr_lo = a; exu_result = res;
        chk("ready_issue", exu_ready, 1);
        step();
        exu_valid = 1'b0;
        exu_result = $urandom;
    endtask

    task automatic check_commit(input logic [4:0] rd, input logic wen,
                                input logic [31:0] data, input logic [31:0] pc);
        chk("wb_done", wb_done, 1);
        chk("rf_we", reg_write_enable, (wen && rd != 0) ? 1 : 0);
        chk("rf_rd", EXrd, rd);
        chk("rf_data", reg_write_data, data);
        chk("wb_pc", wb_pc, pc);
        chk("wb_err", wb_err, exp_err);
    endtask

    task automatic check_quiet();
        chk("quiet_done", wb_done, 0);
        chk("quiet_we", reg_write_enable, 0);
    endtask

    task automatic do_alu(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                          input logic [31:0] res);
        issue(pc, rd, wen, 1'b0, 3'($urandom), 2'($urandom), res);
        check_commit(rd, wen, res, pc);
    endtask

    // dly = edge (counted from acceptance) at which rvalid is sampled; > TMO means never.
    task automatic do_load(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                           input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w,
                           input int dly);
        issue(pc, rd, wen, 1'b1, f3, a, $urandom);
        for (int k = 1; k <= TMO; k++) begin
            chk("ready_wait", exu_ready, 0);
            check_quiet();
            if (k == dly) begin
                lsu_rvalid = 1'b1; lsu_rdata = w;
                step();
                lsu_rvalid = 1'b0; lsu_rdata = $urandom;
                check_commit(rd, wen, ref_load(f3, a, w), pc);
                return;
            end
            lsu_rdata = $urandom;
            step();
        end
        exp_err = 1'b1;
        check_quiet();
        chk("tmo_ready", exu_ready, 1);
        chk("tmo_err", wb_err, 1);
    endtask

    initial begin
        cpu_rst = 1'b1; exu_valid = 1'b0; exu_pc = '0; exu_rd = '0; exu_wen = 1'b0;
        exu_is_load = 1'b0; exu_funct3 = '0; exu_addr_lo = '0; exu_result = '0;
        lsu_rvalid = 1'b0; lsu_rdata = '0;
        step();
        step();
        chk("rst_we", reg_write_enable, 0);
        chk("rst_rd", EXrd, 0);
        chk("rst_data", reg_write_data, 0);
        chk("rst_done", wb_done, 0);
        chk("rst_pc", wb_pc, 0);
        chk("rst_err", wb_err, 0);
        cpu_rst = 1'b0;
        step();
        chk("rst_ready", exu_ready, 1);

        do_alu(32'h8000_0000, 5'd5, 1'b1, 32'hDEAD_BEEF);
        step();
        check_quiet();

        // back-to-back: valid held high, one commit per cycle
        do_alu(32'h8000_0010, 5'd1, 1'b1, 32'h1111_1111);
        do_alu(32'h8000_0014, 5'd2, 1'b1, 32'h2222_2222);
        do_alu(32'h8000_0018, 5'd3, 1'b1, 32'h3333_3333);
        step();
        check_quiet();

        do_load(32'h8000_0100, 5'd7, 1'b1, 3'b000, 2'd3, 32'h8012_3456, 4);
        do_load(32'h8000_0104, 5'd8, 1'b1, 3'b101, 2'd2, 32'h8012_3456, 2);
        do_alu(32'h8000_0108, 5'd0, 1'b1, 32'h1234_5678);
        do_load(32'h8000_010C, 5'd9, 1'b1, 3'b010, 2'd0, 32'hCAFE_F00D, TMO);
        step();
        do_load(32'h8000_0110, 5'd10, 1'b1, 3'b000, 2'd1, 32'h0000_AB00, TMO + 1);
        step();
        check_quiet();

        // reset while waiting for memory drops the load
        issue(32'h8000_0200, 5'd11, 1'b1, 1'b1, 3'b010, 2'd0, 32'h0);
        step();
        #2 cpu_rst = 1'b1;
        exp_err = 1'b0;
        #1;
        chk("arst_rd", EXrd, 0);
        chk("arst_pc", wb_pc, 0);
        chk("arst_err", wb_err, 0);
        step();
        cpu_rst = 1'b0;
        lsu_rvalid = 1'b1; lsu_rdata = 32'h5555_5555;
        step();
        lsu_rvalid = 1'b0;
        check_quiet();
        chk("post_rst_ready", exu_ready, 1);
        chk("post_rst_rd", EXrd, 0);
        chk("post_rst_data", reg_write_data, 0);
        chk("post_rst_pc", wb_pc, 0);
        chk("post_rst_err", wb_err, 0);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] pc;
            logic [4:0]  rd;
            pc = $urandom & 32'hFFFF_FFFC;
            rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            if ($urandom_range(0, 1) == 0)
                do_alu(pc, rd, 1'($urandom), $urandom);
            else
                do_load(pc, rd, 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                        $urandom_range(1, TMO + 1));
            if ($urandom_range(0, 2) == 0) begin
                step();
                check_quiet();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
